// File: rtl/sat_pkg.sv
// Shared types and helpers for the saturating width-reduction stage.
package sat_pkg;

   localparam int SAT_CNT_W = 16;
   localparam int SAT_LIM_W = 64;

   typedef struct packed {
      logic hi;
      logic lo;
   } sat_flags_t;

   // Limits are returned full-width; callers truncate to their OUT_W.
   function automatic logic [SAT_LIM_W-1:0] sat_max(input int w, input bit sgn);
      logic [SAT_LIM_W-1:0] one;
      one = SAT_LIM_W'(1);
      if (sgn) return (one << (w - 1)) - one;
      return (one << w) - one;
   endfunction

   function automatic logic [SAT_LIM_W-1:0] sat_min(input int w, input bit sgn);
      logic [SAT_LIM_W-1:0] one;
      one = SAT_LIM_W'(1);
      if (sgn) return ~((one << (w - 1)) - one);
      return '0;
   endfunction

endpackage

// File: rtl/saturate_sync_if.sv
// Sample stream in, clamped stream plus clip flags and counter out.
interface saturate_sync_if
   import sat_pkg::*;
#(
   parameter int IN_W  = 10,
   parameter int OUT_W = 8
);
   logic                 in_valid;
   logic [IN_W-1:0]      in_data;
   logic                 clr_stats;
   logic                 out_valid;
   logic [OUT_W-1:0]     out_data;
   logic                 sat_hi;
   logic                 sat_lo;
   logic [SAT_CNT_W-1:0] sat_count;

   modport master (
      output in_valid, in_data, clr_stats,
      input  out_valid, out_data, sat_hi, sat_lo, sat_count
   );

   modport slave (
      input  in_valid, in_data, clr_stats,
      output out_valid, out_data, sat_hi, sat_lo, sat_count
   );
endinterface

// File: rtl/sat_clamp_comb.sv
// Purely combinational clamp of an IN_W value into the OUT_W range.
module sat_clamp_comb
   import sat_pkg::*;
#(
   parameter int IN_W   = 10,
   parameter int OUT_W  = 8,
   parameter int SIGNED = 0
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout,
   output sat_flags_t       flags
);
   localparam logic [OUT_W-1:0] MAX_V = OUT_W'(sat_max(OUT_W, SIGNED != 0));
   localparam logic [OUT_W-1:0] MIN_V = OUT_W'(sat_min(OUT_W, SIGNED != 0));
   localparam int               TOP_W = IN_W - OUT_W + 1;

   generate
      if (SIGNED != 0) begin : g_signed
         // In range only when every bit down to the new sign bit matches the old sign.
         logic in_range;
         assign in_range = (din[IN_W-1:OUT_W-1] == {TOP_W{din[IN_W-1]}});

         always_comb begin
            dout  = din[OUT_W-1:0];
            flags = '0;
            if (!in_range) begin
               if (din[IN_W-1]) begin
                  dout     = MIN_V;
                  flags.lo = 1'b1;
               end else begin
                  dout     = MAX_V;
                  flags.hi = 1'b1;
               end
            end
         end
      end else begin : g_unsigned
         always_comb begin
            dout  = din[OUT_W-1:0];
            flags = '0;
            if (|din[IN_W-1:OUT_W]) begin
               dout     = MAX_V;
               flags.hi = 1'b1;
            end
         end
      end
   endgenerate
endmodule

// File: rtl/saturate_sync.sv
// Registered saturating width reduction; optional clip counter under SATURATE_SYNC_STATS_EN.
module saturate_sync
   import sat_pkg::*;
#(
   parameter int IN_W   = 10,
   parameter int OUT_W  = 8,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst,
   saturate_sync_if.slave   bus
);
   logic [OUT_W-1:0] c_data;
   sat_flags_t       c_flags;

   logic             vld_q;
   logic [OUT_W-1:0] data_q;
   sat_flags_t       flags_q;

   sat_clamp_comb #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .SIGNED (SIGNED)
   ) u_clamp (
      .din   (bus.in_data),
      .dout  (c_data),
      .flags (c_flags)
   );

   // Data and flags only move on valid samples; idle cycles hold the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         data_q  <= '0;
         flags_q <= '0;
      end else begin
         vld_q <= bus.in_valid;
         if (bus.in_valid) begin
            data_q  <= c_data;
            flags_q <= c_flags;
         end
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.out_data  = data_q;
   assign bus.sat_hi    = flags_q.hi;
   assign bus.sat_lo    = flags_q.lo;

`ifdef SATURATE_SYNC_STATS_EN
   logic [SAT_CNT_W-1:0] cnt_q;
   logic                 clip;

   assign clip = bus.in_valid && (c_flags.hi || c_flags.lo);

   // Clear wins over a same-cycle increment; the count sticks at all ones.
   always_ff @(posedge clk) begin
      if (rst || bus.clr_stats)
         cnt_q <= '0;
      else if (clip && (cnt_q != {SAT_CNT_W{1'b1}}))
         cnt_q <= cnt_q + SAT_CNT_W'(1);
   end

   assign bus.sat_count = cnt_q;
`else
   logic unused_clr;
   assign unused_clr    = bus.clr_stats;
   assign bus.sat_count = '0;
`endif
endmodule

// File: tb/tb_saturate_sync.sv
// Bench for saturate_sync: unsigned and signed instances driven side by side.
module tb_saturate_sync;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   saturate_sync_if #(.IN_W(10), .OUT_W(8)) u_if ();
   saturate_sync_if #(.IN_W(10), .OUT_W(8)) s_if ();

   saturate_sync #(.IN_W(10), .OUT_W(8), .SIGNED(0)) u_dut (
      .clk (clk), .rst (rst), .bus (u_if.slave));
   saturate_sync #(.IN_W(10), .OUT_W(8), .SIGNED(1)) s_dut (
      .clk (clk), .rst (rst), .bus (s_if.slave));

   int checks = 0;
   int errors = 0;

`ifdef SATURATE_SYNC_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // Reference model state, index 0 = unsigned, 1 = signed
   bit   m_v  [2];
   int   m_d  [2];
   bit   m_hi [2];
   bit   m_lo [2];
   int   m_cnt[2];

   function automatic void ref_clamp(input logic [9:0] d, input bit sgn,
                                     output int q, output bit hi, output bit lo);
      int x;
      hi = 0; lo = 0;
      if (sgn) begin
         x = int'($signed(d));
         if (x > 127)       begin q = 127; hi = 1; end
         else if (x < -128) begin q = -128; lo = 1; end
         else q = x;
         q = q & 255;
      end else begin
         x = int'(d);
         if (x > 255) begin q = 255; hi = 1; end
         else q = x;
      end
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_model();
      chk("u_valid", int'(u_if.out_valid), int'(m_v[0]));
      chk("u_data",  int'(u_if.out_data),  m_d[0]);
      chk("u_hi",    int'(u_if.sat_hi),    int'(m_hi[0]));
      chk("u_lo",    int'(u_if.sat_lo),    int'(m_lo[0]));
      chk("u_count", int'(u_if.sat_count), m_cnt[0]);
      chk("s_valid", int'(s_if.out_valid), int'(m_v[1]));
      chk("s_data",  int'(s_if.out_data),  m_d[1]);
      chk("s_hi",    int'(s_if.sat_hi),    int'(m_hi[1]));
      chk("s_lo",    int'(s_if.sat_lo),    int'(m_lo[1]));
      chk("s_count", int'(s_if.sat_count), m_cnt[1]);
   endtask

   // One clock: drive, take the edge, advance the model, optionally compare.
   task automatic cyc(input bit r, input bit v, input logic [9:0] du,
                      input logic [9:0] ds, input bit clr, input bit do_chk);
      logic [9:0] d[2];
      int q; bit hi, lo;
      rst = r;
      u_if.in_valid = v; u_if.in_data = du; u_if.clr_stats = clr;
      s_if.in_valid = v; s_if.in_data = ds; s_if.clr_stats = clr;
      d[0] = du; d[1] = ds;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            m_v[k] = 0; m_d[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_cnt[k] = 0;
         end else begin
            ref_clamp(d[k], k == 1, q, hi, lo);
            m_v[k] = v;
            if (STATS) begin
               if (clr) m_cnt[k] = 0;
               else if (v && (hi || lo) && m_cnt[k] < 65535) m_cnt[k]++;
            end
            if (v) begin
               m_d[k] = q; m_hi[k] = hi; m_lo[k] = lo;
            end
         end
      end
      if (do_chk) cmp_model();
   endtask

   typedef struct {
      logic [9:0] du;
      logic [9:0] ds;
      int         eu;
      bit         euh;
      int         es;
      bit         esh;
      bit         esl;
   } vec_t;

   vec_t vt[$];

   initial begin
      rst = 1'b1;
      u_if.in_valid = 0; u_if.in_data = '0; u_if.clr_stats = 0;
      s_if.in_valid = 0; s_if.in_data = '0; s_if.clr_stats = 0;

      vt.push_back('{10'd168,  10'd127,  168, 0, 8'h7F, 0, 0});
      vt.push_back('{10'd255,  10'd128,  255, 0, 8'h7F, 1, 0});
      vt.push_back('{10'd256,  10'h380,  255, 1, 8'h80, 0, 0});
      vt.push_back('{10'h3F8,  10'h338,  255, 1, 8'h80, 0, 1});
      vt.push_back('{10'd0,    10'h3FF,  0,   0, 8'hFF, 0, 0});
      vt.push_back('{10'h3FF,  10'h200,  255, 1, 8'h80, 0, 1});
      vt.push_back('{10'd1,    10'h1FF,  1,   0, 8'h7F, 1, 0});

      // Reset holds everything at zero even with valid high
      cyc(1, 1, 10'h3FF, 10'h3FF, 0, 1);
      cyc(1, 1, 10'h3FF, 10'h3FF, 0, 1);

      // Table vectors: first sample right after reset release
      foreach (vt[i]) begin
         cyc(0, 1, vt[i].du, vt[i].ds, 0, 1);
         chk("tbl_u_data", int'(u_if.out_data), vt[i].eu);
         chk("tbl_u_hi",   int'(u_if.sat_hi),   int'(vt[i].euh));
         chk("tbl_s_data", int'(s_if.out_data), vt[i].es);
         chk("tbl_s_hi",   int'(s_if.sat_hi),   int'(vt[i].esh));
         chk("tbl_s_lo",   int'(s_if.sat_lo),   int'(vt[i].esl));
         if (i == 3) chk("tbl_u_count4", int'(u_if.sat_count), STATS ? 2 : 0);
      end

      // Hold/valid and clear priority
      cyc(0, 0, 10'd0, 10'd0, 1, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 10'h3FF, 10'h200, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 10'd5, 10'd5, 0, 1);
      chk("hold_u_data", int'(u_if.out_data), 255);
      chk("hold_u_count", int'(u_if.sat_count), STATS ? 4 : 0);
      cyc(0, 1, 10'h3FF, 10'h200, 1, 1);
      chk("clr_u_count", int'(u_if.sat_count), 0);
      chk("clr_s_count", int'(s_if.sat_count), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         cyc(0, 1'($urandom_range(0, 3) != 0), 10'($urandom), 10'($urandom),
             $urandom_range(0, 31) == 0, 1);

      // Mid-stream reset
      cyc(1, 1, 10'h3FF, 10'h200, 0, 1);

      // Counter saturation: long clipping run, sampled occasionally
      for (int i = 0; i < 65540; i++)
         cyc(0, 1, 10'h3FF, 10'h200, 0, (i % 8192) == 0 || i >= 65530);
      chk("sat_u_count", int'(u_if.sat_count), STATS ? 65535 : 0);
      chk("sat_s_count", int'(s_if.sat_count), STATS ? 65535 : 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
